// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial arithmetic datapath.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SA_WIDTH_DEF = 2;

    // Bits needed to hold values 0..width, never less than one.
    function automatic int cnt_width(input int width);
        int n;
        n = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (width + 1)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell (d, bout) = a_i - b_i - bin.
// With SERIAL_SUB_ADD_MODE_EN the cell also acts as a full adder when add=1.
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic add,
`endif
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a_i ^ b_i ^ bin;
        bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
`ifdef SERIAL_SUB_ADD_MODE_EN
        // bin/bout carry the adder's carry in add mode
        if (add) begin
            bout = (a_i & b_i) | ((a_i ^ b_i) & bin);
        end
`endif
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor y = a - b with start/busy/done handshake.
// Define SERIAL_SUB_ADD_MODE_EN to add an 'add' input selecting y = a + b.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             add,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   y
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] diff_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   y_r;
    logic             last;
    logic             d_bit;
    logic             bout_bit;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             add_r;
`endif

    full_subtractor_bit u_cell (
        .a_i  (a_sh[0]),
        .b_i  (b_sh[0]),
        .bin  (borrow),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .add  (add_r),
`endif
        .d    (d_bit),
        .bout (bout_bit)
    );

    // New bit enters at the MSB so bit i lands at diff[i] after WIDTH shifts.
    generate
        if (WIDTH > 1) begin : g_shift
            assign diff_next = {d_bit, diff[WIDTH-1:1]};
        end else begin : g_single
            assign diff_next = d_bit;
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        state_next = last ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            y_r    <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_r  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        add_r  <= add;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bout_bit;
                    diff   <= diff_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        y_r <= {bout_bit, diff_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign y    = y_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=2 and WIDTH=4.
module tb_serial_subtractor;

    typedef struct {
        logic [4:0] y;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic [2:0] y2;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [4:0] y4;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic       add2;
    logic       add4;
`endif

    int   total;
    int   bad;
    int   cyc;
    exp_t q2[$];
    exp_t q4[$];

    serial_subtractor #(.WIDTH(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .add   (add2),
`endif
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .y     (y2)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .add   (add4),
`endif
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .y     (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per done pulse, checking value and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL w2_unexpected_done y=%b cyc=%0d", y2, cyc);
            end else begin
                e = q2.pop_front();
                if (y2 !== e.y[2:0] || cyc != e.due || busy2 !== 1'b0) begin
                    bad++;
                    $display("FAIL w2_result y=%b want=%b cyc=%0d due=%0d busy=%b",
                             y2, e.y[2:0], cyc, e.due, busy2);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL w4_unexpected_done y=%b cyc=%0d", y4, cyc);
            end else begin
                e = q4.pop_front();
                if (y4 !== e.y || cyc != e.due || busy4 !== 1'b0) begin
                    bad++;
                    $display("FAIL w4_result y=%b want=%b cyc=%0d due=%0d busy=%b",
                             y4, e.y, cyc, e.due, busy4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [2:0] ey, input int due);
        exp_t e;
        e.y   = {2'b00, ey};
        e.due = due;
        q2.push_back(e);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic [2:0] ey);
        start2 = 1'b1;
        a2     = a;
        b2     = b;
        tick();
        push2(ey, cyc + 2);
        check("w2_busy_after_start", {31'd0, busy2}, 32'd1);
        start2 = 1'b0;
        a2     = 2'($urandom);
        b2     = 2'($urandom);
        tick();
        tick();
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] ey);
        exp_t e;
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        tick();
        e.y   = ey;
        e.due = cyc + 4;
        q4.push_back(e);
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        repeat (5) tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        a2     = '0;
        b2     = '0;
        a4     = '0;
        b4     = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add2   = 1'b0;
        add4   = 1'b0;
`endif
        repeat (3) tick();
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        check("rst_done2", {31'd0, done2}, 32'd0);
        check("rst_y2", {29'd0, y2}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_y4", {27'd0, y4}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Exhaustive sweep, issued back-to-back on each DONE cycle.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                op2(2'(a), 2'(b), 3'(a - b));
            end
        end
        op2(2'd3, 2'd1, 3'b010);
        op2(2'd0, 2'd3, 3'b101);
        op2(2'd2, 2'd2, 3'b000);
        repeat (3) tick();

        // Start during RUN must be ignored.
        start2 = 1'b1;
        a2 = 2'd1;
        b2 = 2'd2;
        tick();
        push2(3'b111, cyc + 2);
        a2 = 2'd3;
        b2 = 2'd0;
        tick();
        start2 = 1'b0;
        repeat (6) tick();
        check("ignore_y_hold", {29'd0, y2}, 32'h7);

        // Reset one cycle into RUN aborts with no done.
        start2 = 1'b1;
        a2 = 2'd3;
        b2 = 2'd1;
        tick();
        start2 = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy2}, 32'd0);
        check("abort_done", {31'd0, done2}, 32'd0);
        check("abort_y", {29'd0, y2}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done_y", {29'd0, y2}, 32'd0);
        op2(2'd3, 2'd1, 3'b010);
        repeat (2) tick();

        // Start held high across DONE gives pulses WIDTH+1 apart.
        start2 = 1'b1;
        a2 = 2'd2;
        b2 = 2'd3;
        tick();
        push2(3'b111, cyc + 2);
        a2 = 2'd3;
        b2 = 2'd0;
        tick();
        tick();
        tick();
        push2(3'b011, cyc + 2);
        start2 = 1'b0;
        repeat (5) tick();

        op4(4'd0, 4'd15, 5'b10001);
        op4(4'd15, 4'd0, 5'b01111);
        op4(4'd9, 4'd6, 5'b00011);
        op4(4'd6, 4'd9, 5'b11101);
        op4(4'd15, 4'd15, 5'b00000);

`ifdef SERIAL_SUB_ADD_MODE_EN
        add2 = 1'b1;
        op2(2'd3, 2'd3, 3'b110);
        add2 = 1'b0;
        op2(2'd3, 2'd3, 3'b000);
        add2 = 1'b1;
        op2(2'd2, 2'd1, 3'b011);
        add2 = 1'b0;
        add4 = 1'b1;
        op4(4'd15, 4'd15, 5'b11110);
        add4 = 1'b0;
        op4(4'd15, 4'd15, 5'b00000);
`endif

        repeat (10) tick();
        check("w2_queue_drained", 32'(q2.size()), 32'd0);
        check("w4_queue_drained", 32'(q4.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
